// File: rtl/cn_seq_pkg.sv
// Shared constants for the CryptoNight engine sequencer: state encoding, engine modes and
// the start-synchronizer guard length.
package cn_seq_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StIdle      = 4'd0;
  localparam state_t StLoad      = 4'd1;
  localparam state_t StSetupGo   = 4'd2;
  localparam state_t StSetupWait = 4'd3;
  localparam state_t StIlGo      = 4'd4;
  localparam state_t StIlWait    = 4'd5;
  localparam state_t StMlGo      = 4'd6;
  localparam state_t StMlWait    = 4'd7;
  localparam state_t StFlGo      = 4'd8;
  localparam state_t StFlWait    = 4'd9;
  localparam state_t StDrRd      = 4'd10;
  localparam state_t StDrCap     = 4'd11;
  localparam state_t StDrHold    = 4'd12;
  localparam state_t StErr       = 4'd13;

  localparam logic [1:0] MODE_FL    = 2'd0;
  localparam logic [1:0] MODE_IL    = 2'd1;
  localparam logic [1:0] MODE_SETUP = 2'd2;

  // Cycles after ctrl_start during which sts_finished is not trusted.
  localparam int unsigned START_GUARD = 2;

  function automatic logic is_go(input state_t s);
    return s inside {StSetupGo, StIlGo, StMlGo, StFlGo};
  endfunction

  function automatic logic is_wait(input state_t s);
    return s inside {StSetupWait, StIlWait, StMlWait, StFlWait};
  endfunction

  function automatic logic is_drain(input state_t s);
    return s inside {StDrRd, StDrCap, StDrHold};
  endfunction

endpackage

// File: rtl/cn_seq_watchdog.sv
// Per-phase watchdog: cleared when a phase is launched, counts while waiting on it, and flags
// expiry on the cycle the count would reach its all-ones terminal value.
module cn_seq_watchdog #(
  parameter int unsigned TIMEOUT_LOG2 = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TIMEOUT_LOG2-1:0] cnt_q;
  logic [TIMEOUT_LOG2-1:0] cnt_d;

  assign cnt_d  = cnt_q + TIMEOUT_LOG2'(1);
  assign expire = enable & ~clear & (&cnt_d);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cn_seq_ctrl.sv
// Host-side sequencer for the CryptoNight IL/FL engine: loads the Keccak state into the engine
// buffer, walks setup / IL / main loop / FL, then streams the finalization words out.
module cn_seq_ctrl
  import cn_seq_pkg::*;
#(
  parameter int unsigned LOAD_WORDS   = 16,
  parameter int unsigned STORE_BASE   = 8,
  parameter int unsigned STORE_WORDS  = 8,
  parameter int unsigned TIMEOUT_LOG2 = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         ctrl_start,
  output logic [1:0]   ctrl_mode,
  input  logic         sts_running,
  input  logic         sts_finished,
  output logic [7:0]   reg_address,
  output logic         reg_write,
  output logic [127:0] reg_wrdata,
  input  logic [127:0] reg_rddata,
  output logic         ml_start,
  input  logic         ml_done,
  output logic         busy,
  output logic         error
);

  localparam int unsigned LoadCntW  = $clog2(LOAD_WORDS + 1);
  localparam int unsigned DrainCntW = $clog2(STORE_WORDS + 1);
  localparam int unsigned GuardW    = $clog2(START_GUARD + 1);

  localparam logic [LoadCntW-1:0]  LoadLast  = LoadCntW'(LOAD_WORDS - 1);
  localparam logic [DrainCntW-1:0] DrainLast = DrainCntW'(STORE_WORDS - 1);
  localparam logic [GuardW-1:0]    GuardDone = GuardW'(START_GUARD);

  if (STORE_BASE + STORE_WORDS > 128) begin : gen_cfg_check
    $error("cn_seq_ctrl: drain window exceeds the 128-entry buffer");
  end

  state_t                 state_q, state_d;
  logic [LoadCntW-1:0]    load_cnt_q, load_cnt_d;
  logic [DrainCntW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [GuardW-1:0]      guard_q, guard_d;
  logic [1:0]             ctrl_mode_q;
  logic [127:0]           out_data_q;
  logic                   out_valid_q;

  logic in_hs;
  logic finished_ok;
  logic wd_clear;
  logic wd_enable;
  logic wd_expire;

  // Engine status is informational only; sequencing keys off sts_finished.
  logic unused_sts_running;
  assign unused_sts_running = sts_running;

  assign wd_clear  = is_go(state_q);
  assign wd_enable = is_wait(state_q);

  cn_seq_watchdog #(
    .TIMEOUT_LOG2 (TIMEOUT_LOG2)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expire  (wd_expire)
  );

  assign in_ready    = reset_n & ((state_q == StIdle) | (state_q == StLoad));
  assign in_hs       = in_valid & in_ready;
  assign finished_ok = sts_finished & (guard_q == GuardDone);

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    guard_d     = guard_q;

    if (is_go(state_q)) begin
      guard_d = '0;
    end else if (is_wait(state_q) && (guard_q != GuardDone)) begin
      guard_d = guard_q + GuardW'(1);
    end

    unique case (state_q)
      StIdle, StLoad: begin
        if (in_hs) begin
          if (load_cnt_q == LoadLast) begin
            load_cnt_d = '0;
            state_d    = StSetupGo;
          end else begin
            load_cnt_d = load_cnt_q + LoadCntW'(1);
            state_d    = StLoad;
          end
        end
      end
      StSetupGo: state_d = StSetupWait;
      StIlGo:    state_d = StIlWait;
      StFlGo:    state_d = StFlWait;
      // Finished wins over a simultaneous watchdog expiry.
      StSetupWait: begin
        if (finished_ok)    state_d = StIlGo;
        else if (wd_expire) state_d = StErr;
      end
      StIlWait: begin
        if (finished_ok)    state_d = StMlGo;
        else if (wd_expire) state_d = StErr;
      end
      StFlWait: begin
        if (finished_ok) begin
          drain_cnt_d = '0;
          state_d     = StDrRd;
        end else if (wd_expire) begin
          state_d = StErr;
        end
      end
      StMlGo:   state_d = ml_done ? StFlGo : StMlWait;
      StMlWait: begin
        if (ml_done)        state_d = StFlGo;
        else if (wd_expire) state_d = StErr;
      end
      StDrRd:  state_d = StDrCap;
      StDrCap: state_d = StDrHold;
      StDrHold: begin
        if (out_ready) begin
          if (drain_cnt_q == DrainLast) begin
            drain_cnt_d = '0;
            state_d     = StIdle;
          end else begin
            drain_cnt_d = drain_cnt_q + DrainCntW'(1);
            state_d     = StDrRd;
          end
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      guard_q     <= '0;
      ctrl_mode_q <= MODE_FL;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      guard_q     <= guard_d;

      // Mode only moves on entry to a launch state, never mid-phase.
      if (state_d == StSetupGo) begin
        ctrl_mode_q <= MODE_SETUP;
      end else if (state_d == StIlGo) begin
        ctrl_mode_q <= MODE_IL;
      end else if (state_d == StFlGo) begin
        ctrl_mode_q <= MODE_FL;
      end

      if (state_q == StDrCap) begin
        out_data_q  <= reg_rddata;
        out_valid_q <= 1'b1;
      end else if ((state_q == StDrHold) && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    reg_address = '0;
    if (in_ready) begin
      reg_address = 8'(load_cnt_q);
    end else if (is_drain(state_q)) begin
      reg_address = 8'(STORE_BASE) + 8'(drain_cnt_q);
    end
  end

  assign reg_write  = in_hs;
  assign reg_wrdata = in_ready ? in_data : '0;

  assign ctrl_start = reset_n & ((state_q == StSetupGo) | (state_q == StIlGo) |
                                 (state_q == StFlGo));
  assign ml_start   = reset_n & (state_q == StMlGo);
  assign ctrl_mode  = ctrl_mode_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != StIdle) & (state_q != StErr);
  assign error      = (state_q == StErr);

endmodule

// File: tb/tb_cn_seq_ctrl.sv
// Directed bench for cn_seq_ctrl: load, phase sequencing, drain backpressure, start guard,
// watchdog timeout and mid-phase reset, against a small buffer-RAM and engine model.
module tb_cn_seq_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         ctrl_start;
  logic [1:0]   ctrl_mode;
  logic         sts_running;
  logic         sts_finished;
  logic [7:0]   reg_address;
  logic         reg_write;
  logic [127:0] reg_wrdata;
  logic [127:0] reg_rddata;
  logic         ml_start;
  logic         ml_done;
  logic         busy;
  logic         error;

  int n_assert = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int ml_cnt    = 0;
  logic [1:0] mode_log[$];
  logic [127:0] mem [0:255];

  always #5 clk = ~clk;

  cn_seq_ctrl #(
    .LOAD_WORDS   (16),
    .STORE_BASE   (8),
    .STORE_WORDS  (8),
    .TIMEOUT_LOG2 (6)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .ctrl_start   (ctrl_start),
    .ctrl_mode    (ctrl_mode),
    .sts_running  (sts_running),
    .sts_finished (sts_finished),
    .reg_address  (reg_address),
    .reg_write    (reg_write),
    .reg_wrdata   (reg_wrdata),
    .reg_rddata   (reg_rddata),
    .ml_start     (ml_start),
    .ml_done      (ml_done),
    .busy         (busy),
    .error        (error)
  );

  // Buffer RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (reg_write) mem[reg_address] <= reg_wrdata;
    reg_rddata <= mem[reg_address];
  end

  always @(negedge clk) begin
    if (ctrl_start) begin
      start_cnt++;
      mode_log.push_back(ctrl_mode);
    end
    if (ml_start) ml_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish, required finish before 100000");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input bit pat_a);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      w        = (pat_a && i >= 8) ? 128'(160 + i - 8) : 128'(i);
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      chk("load_we", reg_write, 1'b1);
      chk("load_addr", reg_address, 8'(i));
      chk("load_data", reg_wrdata, w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_start(input string tag, input logic [1:0] mode);
    @(negedge clk);
    chk({tag, "_start"}, ctrl_start, 1'b1);
    chk({tag, "_mode"}, ctrl_mode, mode);
  endtask

  // Engine model, entered at the negedge of the ctrl_start cycle.
  task automatic engine(input int early_at, input int fin_at);
    int snap;
    snap = 0;
    for (int c = 1; c <= fin_at; c++) begin
      @(posedge clk); #1;
      sts_running  = 1'b1;
      sts_finished = (c == early_at) || (c == fin_at);
      if (c == 1) snap = start_cnt;
      if (early_at > 0 && c == early_at + 3) chk("early_ignored", start_cnt, snap);
    end
    @(posedge clk); #1;
    sts_finished = 1'b0;
    sts_running  = 1'b0;
  endtask

  task automatic drain(input logic [127:0] base, input int stall_word);
    int n;
    for (int w = 0; w < 8; w++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid && n < 8);
      chk("drain_lat", n, 3);
      chk("drain_data", out_data, base + 128'(w));
      chk("drain_we", reg_write, 1'b0);
      if (w == stall_word) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_data", out_data, base + 128'(w));
        end
        out_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int snap;
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b1;
    sts_running  = 1'b0;
    sts_finished = 1'b0;
    ml_done      = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_ctrl_start", ctrl_start, 1'b0);
    chk("rst_ctrl_mode", ctrl_mode, 2'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_reg_address", reg_address, 8'd0);
    chk("rst_ml_start", ml_start, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);

    // Run 1: plain load, 40-cycle phases, ml_done after 10, drain without stalls.
    load(1'b0);
    expect_start("setup1", 2'd2);
    chk("go_in_ready", in_ready, 1'b0);
    chk("go_busy", busy, 1'b1);
    engine(2, 40);
    expect_start("il1", 2'd1);
    engine(0, 40);
    @(negedge clk);
    chk("ml_start1", ml_start, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      ml_done = (c == 10);
      if (c == 5) chk("ml_wait_no_pulse", ml_start, 1'b0);
    end
    @(posedge clk); #1;
    ml_done = 1'b0;
    expect_start("fl1", 2'd0);
    engine(0, 3);
    drain(128'h08, -1);
    chk("run1_busy", busy, 1'b0);
    chk("run1_in_ready", in_ready, 1'b1);
    chk("run1_starts", start_cnt, 3);
    chk("run1_ml_starts", ml_cnt, 1);
    chk("run1_mode0", mode_log[0], 2'd2);
    chk("run1_mode1", mode_log[1], 2'd1);
    chk("run1_mode2", mode_log[2], 2'd0);

    // Run 2: guard boundary, early finish ignored, same-cycle ml_done, drain backpressure.
    load(1'b1);
    expect_start("setup2", 2'd2);
    engine(0, 3);
    expect_start("il2", 2'd1);
    engine(1, 30);
    @(negedge clk);
    chk("ml_start2", ml_start, 1'b1);
    ml_done = 1'b1;
    @(posedge clk); #1;
    ml_done = 1'b0;
    expect_start("fl2", 2'd0);
    engine(0, 40);
    drain(128'hA0, 2);
    chk("run2_busy", busy, 1'b0);
    chk("run2_starts", start_cnt, 6);

    // Run 3: engine never finishes setup.
    load(1'b0);
    expect_start("setup3", 2'd2);
    repeat (63) @(negedge clk);
    chk("wd_not_yet_error", error, 1'b0);
    chk("wd_not_yet_busy", busy, 1'b1);
    @(negedge clk);
    chk("wd_error", error, 1'b1);
    chk("wd_busy", busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("wd_sticky", error, 1'b1);
    chk("wd_no_start", start_cnt, 7);

    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("err_clear", error, 1'b0);
    chk("err_in_ready", in_ready, 1'b1);

    // Run 4: reset during IL_WAIT, then a clean fresh run.
    load(1'b1);
    expect_start("setup4", 2'd2);
    engine(0, 3);
    expect_start("il4", 2'd1);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mode", ctrl_mode, 2'd0);
    chk("midrst_out_data", out_data, 128'd0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_start", ctrl_start, 1'b0);
    snap = start_cnt;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle_ready", in_ready, 1'b1);
    repeat (5) @(negedge clk);
    chk("midrst_no_pulse", start_cnt, snap);
    load(1'b1);
    expect_start("setup5", 2'd2);
    engine(0, 3);
    expect_start("il5", 2'd1);
    engine(0, 3);
    @(negedge clk);
    chk("ml_start5", ml_start, 1'b1);
    ml_done = 1'b1;
    @(posedge clk); #1;
    ml_done = 1'b0;
    expect_start("fl5", 2'd0);
    engine(0, 3);
    drain(128'hA0, -1);
    chk("run5_busy", busy, 1'b0);
    chk("run5_starts", start_cnt, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cn_seq_ctrl.md
Name: cn_seq_ctrl

Overview:
Host-side sequencer that drives the control and buffer-RAM register port of the CryptoNight IL/FL engine (the initiator of ctrl_start/ctrl_mode/reg_*).
- Streams the Keccak state words into the engine's buffer RAM.
- Runs setup, then initial loop (IL), then hands off to the main-loop block, then runs final loop (FL).
- Drains the finalization words out as a stream.
- Sits between the Keccak front-end and the final hash stage.

Parameters:
LOAD_WORDS, 16, number of 128-bit words written to buffer addresses 0..LOAD_WORDS-1.
STORE_BASE, 8, first buffer address drained after FL (equals Z_ADDR).
STORE_WORDS, 8, number of words drained.
TIMEOUT_LOG2, 24, per-phase watchdog length is 2^TIMEOUT_LOG2 cycles.

Ports:
clk  in  1  clock
reset_n  in  1  reset; synchronous, active-low
in_valid  in  1  input word valid
in_ready  out  1  input word accepted
in_data  in  128  input word
out_valid  out  1  drained word valid
out_ready  in  1  downstream accepts
out_data  out  128  drained word
ctrl_start  out  1  engine start pulse
ctrl_mode  out  2  0=FL, 1=IL, 2=setup
sts_running  in  1  engine running
sts_finished  in  1  engine one-cycle done pulse
reg_address  out  8  buffer port address
reg_write  out  1  buffer port write enable
reg_wrdata  out  128  buffer write data
reg_rddata  in  128  buffer read data, valid one cycle after reg_address
ml_start  out  1  main-loop start pulse
ml_done  in  1  main-loop done pulse
busy  out  1  state != IDLE and != ERR
error  out  1  sticky watchdog error

Behaviour:
- Reset: only synchronous reset_n=0 at a clk edge resets. Results: state=IDLE; all outputs 0 (including ctrl_mode=0, out_data=0); counters 0. Reset mid-operation aborts immediately, with no drain and no pulse.
- IDLE: in_ready=1. The first in handshake writes word 0 and enters LOAD.
- LOAD: in_ready=1.
  - reg_write = in_valid & in_ready (combinational), reg_address = load_cnt, reg_wrdata = in_data.
  - load_cnt increments per handshake.
  - After the handshake with load_cnt==LOAD_WORDS-1, go to SETUP_GO.
  - in_ready=0 in all other states.
- X_GO (X = SETUP/IL/FL, mode 2/1/0):
  - ctrl_mode is registered to the phase mode on entry.
  - ctrl_start=1 for exactly one cycle, then go to X_WAIT.
  - ctrl_mode holds its value until the next X_GO; it is never changed while sts_running=1.
- X_WAIT: wait for sts_finished=1, then go to the next phase. Order is SETUP→IL→ML_GO, and FL→DRAIN.
  - sts_finished is ignored for the first 2 cycles after ctrl_start, covering the engine's 2-cycle start synchronizer.
  - ctrl_start stays 0 for at least 3 cycles between pulses.
- ML_GO: ml_start pulses 1 cycle, then ML_WAIT.
- ML_WAIT: ml_done goes to FL_GO. If ml_done arrives in the same cycle as ml_start, it is honoured.
- Watchdog:
  - Counter cleared on each GO, incrementing in WAIT states.
  - Reaching 2^TIMEOUT_LOG2-1 goes to ERR.
  - ERR: error=1, busy=0; stays until reset.
- DRAIN, three sub-states per word:
  - RD: reg_address = STORE_BASE + drain_cnt.
  - CAP: out_data <= reg_rddata, out_valid=1.
  - HOLD: out_valid held, out_data stable, until out_ready.
  - Throughput: 1 word / 3 cycles minimum.
  - After the handshake on drain_cnt==STORE_WORDS-1, go to IDLE.
  - reg_write=0 throughout DRAIN.
- Widths:
  - load_cnt: $clog2(LOAD_WORDS+1).
  - drain_cnt: $clog2(STORE_WORDS+1).
  - reg_address sums truncate to 8 bits.
  - Elaboration error if STORE_BASE+STORE_WORDS > 128.
- Simultaneous events: sts_finished together with a watchdog expiry gives finished priority.

Decomposition:
- Package cn_seq_pkg:
  - state enum;
  - mode constants MODE_FL=0, MODE_IL=1, MODE_SETUP=2;
  - START_GUARD=2.
- One natural sub-module: cn_seq_watchdog (clear/enable/expire counter, parameter TIMEOUT_LOG2).

Test Plan:
1. Load: 16 words 0x00..0F with in_valid held → reg_write on 16 consecutive cycles, addresses 0..15; then exactly one ctrl_start with ctrl_mode=2.
2. Phase sequence: model engine, finished 40 cycles after start → observe modes 2,1 then ml_start; ml_done after 10 cycles → mode 0 start; exactly 3 ctrl_start pulses total.
3. Drain backpressure: buffer[8..15]=0xA0..A7, out_ready low 5 cycles on word 2 → out_data stable 0xA2 while held; 8 words in order; then busy=0.
4. Early finished: sts_finished asserted 1 cycle after ctrl_start → ignored; later pulse at +30 advances.
5. Timeout: TIMEOUT_LOG2=6, engine never finishes → error=1 after 63 WAIT cycles, busy=0, no further ctrl_start.
6. Reset mid-IL: reset_n=0 one cycle during IL_WAIT → all outputs 0, IDLE, in_ready=1 next cycle; a fresh load restarts cleanly.
